// File: rtl/param_node_merge_if.sv
// Bundle of the merge node's channels: N input channels, one select-token channel,
// the tagged output channel, and status/debug observation signals.
interface param_node_merge_if #(
    parameter int N     = 4,
    parameter int W     = 11,
    parameter int DEPTH = 2
) ();
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  ctrl_sel;
    logic           ctrl_valid;
    logic           ctrl_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;
    logic           out_valid;
    logic           out_ready;
    logic           sel_err;
    logic [CW-1:0]  fifo_count;
    logic [SW-1:0]  dbg_rr_ptr;

    // Every channel: a transfer happens on a rising edge where valid && ready; a sender
    // holds its data stable while valid && !ready, and ready never depends on out_ready.
    modport master (
        output in_data, in_valid, ctrl_sel, ctrl_valid, out_ready,
        input  in_ready, ctrl_ready, out_data, out_src, out_valid, sel_err, fifo_count,
               dbg_rr_ptr
    );

    modport slave (
        input  in_data, in_valid, ctrl_sel, ctrl_valid, out_ready,
        output in_ready, ctrl_ready, out_data, out_src, out_valid, sel_err, fifo_count,
               dbg_rr_ptr
    );
endinterface

// File: rtl/param_node_merge.sv
// N-way merge node: picks one input per cycle (select token or round-robin) and queues
// {source, data} in a DEPTH-entry FIFO that drives the output channel.
module param_node_merge #(
    parameter int N        = 4,
    parameter int W        = 11,
    parameter int DEPTH    = 2,
    parameter int ARB_MODE = 0
) (
    input logic              CLK,
    input logic              RESET,
    param_node_merge_if.slave bus
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SW:0]   NUM_IN   = (SW + 1)'(N);
    localparam logic [SW-1:0] LAST_IN  = SW'(N - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [SW+W-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [SW-1:0]   r_rr_ptr;
    logic            r_sel_err;

    logic            w_accept;
    logic            w_found;
    logic            w_push;
    logic            w_pop;
    logic            w_sel_err;
    logic            w_ctrl_ready;
    logic [N-1:0]    w_in_ready;
    logic [SW-1:0]   w_idx;
    logic [SW-1:0]   w_push_src;
    logic [W-1:0]    w_push_data;
    logic [SW-1:0]   w_rr_next;

    // Push eligibility looks only at occupancy, so a full FIFO stalls even while popping.
    assign w_accept = !RESET && (r_count < FULL_CNT);
    assign w_pop    = (r_count != '0) && bus.out_ready;

    always_comb begin
        w_found      = 1'b0;
        w_push       = 1'b0;
        w_sel_err    = 1'b0;
        w_ctrl_ready = 1'b0;
        w_in_ready   = '0;
        w_idx        = '0;
        w_push_src   = '0;
        w_push_data  = '0;
        if (ARB_MODE != 0) begin
            for (int k = 0; k < N; k++) begin
                w_idx = SW'((int'(r_rr_ptr) + k) % N);
                if (!w_found && bus.in_valid[w_idx]) begin
                    w_found    = 1'b1;
                    w_push_src = w_idx;
                end
            end
            w_push = w_found && w_accept;
        end else if (bus.ctrl_valid && w_accept) begin
            if ({1'b0, bus.ctrl_sel} < NUM_IN) begin
                w_push_src = bus.ctrl_sel;
                for (int i = 0; i < N; i++) begin
                    if (SW'(i) == bus.ctrl_sel) w_found = bus.in_valid[i];
                end
                w_push       = w_found;
                w_ctrl_ready = w_found;
            end else begin
                // Out-of-range token is swallowed without touching any input.
                w_ctrl_ready = 1'b1;
                w_sel_err    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (w_push && (SW'(i) == w_push_src)) begin
                w_in_ready[i] = 1'b1;
                w_push_data   = bus.in_data[i*W +: W];
            end
        end
    end

    assign w_rr_next = (w_push_src == LAST_IN) ? '0 : w_push_src + 1'b1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rr_ptr  <= '0;
            r_sel_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_sel_err <= w_sel_err;
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_push_src, w_push_data};
                r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
                if (ARB_MODE != 0) r_rr_ptr <= w_rr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready                = w_in_ready;
    assign bus.ctrl_ready              = w_ctrl_ready;
    assign bus.out_valid               = (r_count != '0);
    assign {bus.out_src, bus.out_data} = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign bus.sel_err                 = r_sel_err;
    assign bus.fifo_count              = r_count;
    assign bus.dbg_rr_ptr              = r_rr_ptr;
endmodule

// File: tb/tb_param_node_merge.sv
// Bench for param_node_merge: CTRL N=4, CTRL N=3 and ARB N=4 instances driven with
// directed vectors, plus a round-robin phase checked against a queue model.
module tb_param_node_merge;
    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    param_node_merge_if #(.N(4), .W(11), .DEPTH(2)) if_c ();
    param_node_merge_if #(.N(3), .W(11), .DEPTH(2)) if_3 ();
    param_node_merge_if #(.N(4), .W(11), .DEPTH(2)) if_a ();

    param_node_merge #(.N(4), .W(11), .DEPTH(2), .ARB_MODE(0)) u_ctrl (
        .CLK(CLK), .RESET(RESET), .bus(if_c));
    param_node_merge #(.N(3), .W(11), .DEPTH(2), .ARB_MODE(0)) u_n3 (
        .CLK(CLK), .RESET(RESET), .bus(if_3));
    param_node_merge #(.N(4), .W(11), .DEPTH(2), .ARB_MODE(1)) u_arb (
        .CLK(CLK), .RESET(RESET), .bus(if_a));

    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0] exp_q[$];
    logic        rv[4];
    logic [10:0] rd[4];
    int          mrr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_all();
        if_c.in_data = '0; if_c.in_valid = '0; if_c.ctrl_sel = '0; if_c.ctrl_valid = 1'b0;
        if_c.out_ready = 1'b0;
        if_3.in_data = '0; if_3.in_valid = '0; if_3.ctrl_sel = '0; if_3.ctrl_valid = 1'b0;
        if_3.out_ready = 1'b0;
        if_a.in_data = '0; if_a.in_valid = '0; if_a.ctrl_sel = '0; if_a.ctrl_valid = 1'b0;
        if_a.out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        found, acc;
        int          g, idx;
        logic [3:0]  exp_rdy;

        // Reset: offer a transfer and confirm nothing is ready while RESET is high.
        RESET = 1'b1;
        idle_all();
        if_c.ctrl_valid = 1'b1; if_c.in_valid = 4'b0001;
        #3;
        check_eq("rst_in_ready",   if_c.in_ready,   0);
        check_eq("rst_ctrl_ready", if_c.ctrl_ready, 0);
        check_eq("rst_out_valid",  if_c.out_valid,  0);
        check_eq("rst_count",      if_c.fifo_count, 0);
        check_eq("rst_sel_err",    if_c.sel_err,    0);
        check_eq("rst_out_data",   if_c.out_data,   0);
        check_eq("rst_rr_ptr",     if_a.dbg_rr_ptr, 0);
        idle_all();
        @(negedge CLK);
        RESET = 1'b0;
        tick();

        // 1: CTRL select 2.
        if_c.ctrl_sel = 2'd2; if_c.ctrl_valid = 1'b1; if_c.in_valid = 4'b0100;
        if_c.in_data[2*11 +: 11] = 11'h005; if_c.out_ready = 1'b1;
        #1;
        check_eq("t1_ctrl_ready", if_c.ctrl_ready, 1);
        check_eq("t1_in_ready",   if_c.in_ready,   4'b0100);
        tick();
        if_c.ctrl_valid = 1'b0; if_c.in_valid = '0;
        #1;
        check_eq("t1_out_valid", if_c.out_valid, 1);
        check_eq("t1_out_data",  if_c.out_data,  11'h005);
        check_eq("t1_out_src",   if_c.out_src,   2);
        tick();
        check_eq("t1_drained", if_c.fifo_count, 0);

        // 2: backpressure with three offers.
        if_c.out_ready = 1'b0;
        if_c.in_data[0*11 +: 11] = 11'h100;
        if_c.in_data[1*11 +: 11] = 11'h101;
        if_c.in_data[3*11 +: 11] = 11'h103;
        if_c.ctrl_valid = 1'b1; if_c.ctrl_sel = 2'd0; if_c.in_valid = 4'b0001;
        #1;
        check_eq("t2_rdy0", if_c.in_ready, 4'b0001);
        tick();
        if_c.ctrl_sel = 2'd1; if_c.in_valid = 4'b0010;
        #1;
        check_eq("t2_rdy1", if_c.in_ready, 4'b0010);
        tick();
        if_c.ctrl_sel = 2'd3; if_c.in_valid = 4'b1000;
        #1;
        check_eq("t2_count_full", if_c.fifo_count, 2);
        check_eq("t2_stall_in",   if_c.in_ready,   0);
        check_eq("t2_stall_ctrl", if_c.ctrl_ready, 0);
        tick();
        check_eq("t2_still_full", if_c.fifo_count, 2);
        if_c.out_ready = 1'b1;
        #1;
        check_eq("t2_no_out_path", if_c.in_ready, 0);
        check_eq("t2_src0",  if_c.out_src,  0);
        check_eq("t2_data0", if_c.out_data, 11'h100);
        tick();
        check_eq("t2_src1",     if_c.out_src,    1);
        check_eq("t2_data1",    if_c.out_data,   11'h101);
        check_eq("t2_cnt_pop",  if_c.fifo_count, 1);
        check_eq("t2_rdy3",     if_c.in_ready,   4'b1000);
        tick();
        if_c.ctrl_valid = 1'b0; if_c.in_valid = '0;
        #1;
        check_eq("t2_src3",     if_c.out_src,    3);
        check_eq("t2_data3",    if_c.out_data,   11'h103);
        check_eq("t2_cnt_same", if_c.fifo_count, 1);
        tick();
        check_eq("t2_empty", if_c.out_valid, 0);

        // 3: N=3, out-of-range select.
        if_3.in_valid = 3'b111; if_3.ctrl_sel = 2'd3; if_3.ctrl_valid = 1'b1;
        if_3.out_ready = 1'b1; if_3.in_data[1*11 +: 11] = 11'h7ff;
        #1;
        check_eq("t3_ctrl_ready", if_3.ctrl_ready, 1);
        check_eq("t3_in_ready",   if_3.in_ready,   0);
        tick();
        if_3.ctrl_valid = 1'b0;
        #1;
        check_eq("t3_sel_err",   if_3.sel_err,    1);
        check_eq("t3_no_output", if_3.out_valid,  0);
        check_eq("t3_count",     if_3.fifo_count, 0);
        tick();
        check_eq("t3_err_pulse", if_3.sel_err, 0);
        if_3.ctrl_sel = 2'd1; if_3.ctrl_valid = 1'b1;
        #1;
        check_eq("t3_rdy1", if_3.in_ready, 3'b010);
        tick();
        if_3.ctrl_valid = 1'b0; if_3.in_valid = '0;
        #1;
        check_eq("t3_src1",  if_3.out_src,  1);
        check_eq("t3_data1", if_3.out_data, 11'h7ff);

        // 4: ARB, all inputs valid.
        for (int i = 0; i < 4; i++) if_a.in_data[i*11 +: 11] = 11'(16 + i);
        if_a.in_valid = 4'hf; if_a.out_ready = 1'b1; if_a.ctrl_valid = 1'b1;
        #1;
        check_eq("t4_grant0",     if_a.in_ready,   4'b0001);
        check_eq("t4_ctrl_ready", if_a.ctrl_ready, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq("t4_src",  if_a.out_src,  k % 4);
            check_eq("t4_data", if_a.out_data, 16 + (k % 4));
        end
        if_a.in_valid = '0; if_a.ctrl_valid = 1'b0;
        #1;
        check_eq("t4_rr", if_a.dbg_rr_ptr, 2);
        tick();
        check_eq("t4_drained", if_a.fifo_count, 0);

        // 5: ARB from rr_ptr=2 with inputs 3 and 1 valid.
        if_a.in_valid = 4'b1010;
        #1;
        check_eq("t5_grant3", if_a.in_ready, 4'b1000);
        tick();
        check_eq("t5_rr0",    if_a.dbg_rr_ptr, 0);
        check_eq("t5_src3",   if_a.out_src,    3);
        check_eq("t5_grant1", if_a.in_ready,   4'b0010);
        tick();
        if_a.in_valid = '0;
        #1;
        check_eq("t5_rr2",  if_a.dbg_rr_ptr, 2);
        check_eq("t5_src1", if_a.out_src,    1);
        tick();
        check_eq("t5_drained", if_a.fifo_count, 0);

        // Randomised ARB traffic against a queue model with a round-robin pointer.
        mrr = 2;
        for (int i = 0; i < 4; i++) begin rv[i] = 1'b0; rd[i] = '0; end
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!rv[i] && ($urandom_range(0, 1) == 1)) begin
                    rv[i] = 1'b1;
                    rd[i] = 11'($urandom_range(0, 2047));
                end
                if_a.in_valid[i]         = rv[i];
                if_a.in_data[i*11 +: 11] = rd[i];
            end
            if_a.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            found = 1'b0; g = 0;
            for (int k = 0; k < 4; k++) begin
                idx = (mrr + k) % 4;
                if (!found && rv[idx]) begin found = 1'b1; g = idx; end
            end
            acc     = (exp_q.size() < 2);
            exp_rdy = (acc && found) ? 4'(1 << g) : 4'b0000;
            check_eq("rnd_ready", if_a.in_ready,  exp_rdy);
            check_eq("rnd_valid", if_a.out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check_eq("rnd_head", {if_a.out_src, if_a.out_data}, exp_q[0]);
                if (if_a.out_ready) void'(exp_q.pop_front());
            end
            if (acc && found) begin
                exp_q.push_back({2'(g), rd[g]});
                rv[g] = 1'b0;
                mrr   = (g + 1) % 4;
            end
            tick();
        end
        if_a.in_valid = '0; if_a.out_ready = 1'b1;
        tick(); tick(); tick();
        check_eq("rnd_drained", if_a.fifo_count, 0);

        // 6: fill the FIFO, then reset mid-cycle.
        if_c.out_ready = 1'b0;
        if_c.in_data[0*11 +: 11] = 11'h0aa;
        if_c.in_data[2*11 +: 11] = 11'h2aa;
        if_c.ctrl_valid = 1'b1; if_c.ctrl_sel = 2'd0; if_c.in_valid = 4'b0001;
        tick();
        if_c.ctrl_sel = 2'd1; if_c.in_valid = 4'b0010;
        tick();
        if_c.ctrl_sel = 2'd2; if_c.in_valid = 4'b0100;
        #1;
        check_eq("t6_full",      if_c.fifo_count, 2);
        check_eq("t6_valid_pre", if_c.out_valid,  1);
        #1;
        RESET = 1'b1;
        #1;
        check_eq("t6_rst_valid", if_c.out_valid,  0);
        check_eq("t6_rst_count", if_c.fifo_count, 0);
        check_eq("t6_rst_data",  if_c.out_data,   0);
        check_eq("t6_rst_in",    if_c.in_ready,   0);
        check_eq("t6_rst_ctrl",  if_c.ctrl_ready, 0);
        check_eq("t6_rst_rr",    if_a.dbg_rr_ptr, 0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check_eq("t6_first_accept", if_c.in_ready, 4'b0100);
        tick();
        if_c.ctrl_valid = 1'b0; if_c.in_valid = '0;
        #1;
        check_eq("t6_count", if_c.fifo_count, 1);
        check_eq("t6_src",   if_c.out_src,    2);
        check_eq("t6_data",  if_c.out_data,   11'h2aa);
        if_c.out_ready = 1'b1;
        tick();
        check_eq("t6_drained", if_c.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
